// File: rtl/matcher_pkg.sv
// matcher_pkg: shared types and constants for the vocab_matcher block.
//   state_t : search FSM states
//   NUL     : terminator character value
package matcher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CMP,
    ST_SKIP_RD,
    ST_SKIP,
    ST_DONE
  } state_t;

  localparam int NUL = 0;

endpackage

// File: rtl/vocab_matcher_if.sv
// vocab_matcher_if: host-side bus of the vocabulary matcher.
//   ld_we/ld_addr/ld_data : vocab load port (host -> matcher)
//   start/word            : search request (host -> matcher)
//   busy/done/match/match_idx/match_addr/overflow_err : status (matcher -> host)
// master = host / word-capture side, slave = matcher.
interface vocab_matcher_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int WORD_LENGTH = 3
);
  logic                              ld_we;
  logic [ADDR_WIDTH-1:0]             ld_addr;
  logic [DATA_WIDTH-1:0]             ld_data;
  logic                              start;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word;
  logic                              busy;
  logic                              done;
  logic                              match;
  logic [ADDR_WIDTH-1:0]             match_idx;
  logic [ADDR_WIDTH-1:0]             match_addr;
  logic                              overflow_err;

  modport master (
    output ld_we, ld_addr, ld_data, start, word,
    input  busy, done, match, match_idx, match_addr, overflow_err
  );

  modport slave (
    input  ld_we, ld_addr, ld_data, start, word,
    output busy, done, match, match_idx, match_addr, overflow_err
  );
endinterface

// File: rtl/vocab_sram.sv
// vocab_sram: single-port synchronous SRAM, DATA_WIDTH x 2**ADDR_WIDTH.
//   clk   : clock
//   we    : write enable (write lands at the clock edge)
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data, one cycle after addr is presented
// The array has no reset so the vocabulary survives a matcher reset.
module vocab_sram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vocab_matcher.sv
// vocab_matcher: searches a NUL-terminated query against NUL-separated words
// in an internal SRAM, reporting match, word index and word start address.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : vocab_matcher_if.slave (load port, start/word, status)
// Each SRAM read costs two cycles (address phase, data phase), so a search
// with N reads raises done in cycle 2N+1 after the start cycle.
module vocab_matcher
  import matcher_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int WORD_LENGTH = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  vocab_matcher_if.slave bus
);

  localparam int WPW = $clog2(WORD_LENGTH + 1);
  localparam logic [DATA_WIDTH-1:0] NUL_C = DATA_WIDTH'(NUL);

  state_t                            state, state_nx;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] qword;
  logic [ADDR_WIDTH-1:0]             vaddr, vaddr_nx;
  logic [WPW-1:0]                    wpos, wpos_nx;
  logic [ADDR_WIDTH-1:0]             widx, widx_nx;
  logic [ADDR_WIDTH-1:0]             wstart, wstart_nx;
  logic                              match_q, match_nx;
  logic                              ovf_q, ovf_nx;
  logic [ADDR_WIDTH-1:0]             idx_q, idx_nx;
  logic [ADDR_WIDTH-1:0]             maddr_q, maddr_nx;
  logic                              busy_q, done_q;

  logic                              sram_we;
  logic [ADDR_WIDTH-1:0]             sram_addr;
  logic [DATA_WIDTH-1:0]             c;
  logic [DATA_WIDTH-1:0]             qchar;
  logic                              last;

  // Load port owns the SRAM only while idle; otherwise the walker reads.
  always_comb begin
    sram_we   = 1'b0;
    sram_addr = vaddr;
    if (state == ST_IDLE) begin
      sram_we   = bus.ld_we;
      sram_addr = bus.ld_addr;
    end
  end

  vocab_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (bus.ld_data),
    .rdata (c)
  );

  // Query char at wpos; position WORD_LENGTH reads as an implicit NUL.
  always_comb begin
    qchar = NUL_C;
    for (int i = 0; i < WORD_LENGTH; i++)
      if (wpos == WPW'(i)) qchar = qword[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign last = &vaddr;

  always_comb begin
    state_nx  = state;
    vaddr_nx  = vaddr;
    wpos_nx   = wpos;
    widx_nx   = widx;
    wstart_nx = wstart;
    match_nx  = match_q;
    ovf_nx    = ovf_q;
    idx_nx    = idx_q;
    maddr_nx  = maddr_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          vaddr_nx  = '0;
          wpos_nx   = '0;
          widx_nx   = '0;
          wstart_nx = '0;
          match_nx  = 1'b0;
          ovf_nx    = 1'b0;
          state_nx  = ST_RD;
        end
      end
      ST_RD:      state_nx = ST_CMP;
      ST_SKIP_RD: state_nx = ST_SKIP;
      ST_CMP: begin
        if (c == NUL_C && wpos == '0) begin
          match_nx = 1'b0;                     // empty word: end of vocab
          state_nx = ST_DONE;
        end else if (c == qchar && c == NUL_C) begin
          match_nx = 1'b1;
          idx_nx   = widx;
          maddr_nx = wstart;
          state_nx = ST_DONE;
        end else if (last) begin
          ovf_nx   = 1'b1;                     // every remaining case advances
          match_nx = 1'b0;
          state_nx = ST_DONE;
        end else if (c == qchar) begin
          vaddr_nx = vaddr + ADDR_WIDTH'(1);
          wpos_nx  = wpos + WPW'(1);
          state_nx = ST_RD;
        end else if (c == NUL_C) begin
          widx_nx   = widx + ADDR_WIDTH'(1);
          wpos_nx   = '0;
          wstart_nx = vaddr + ADDR_WIDTH'(1);
          vaddr_nx  = vaddr + ADDR_WIDTH'(1);
          state_nx  = ST_RD;
        end else begin
          vaddr_nx = vaddr + ADDR_WIDTH'(1);
          state_nx = ST_SKIP_RD;
        end
      end
      ST_SKIP: begin
        if (last) begin
          ovf_nx   = 1'b1;
          match_nx = 1'b0;
          state_nx = ST_DONE;
        end else if (c == NUL_C) begin
          widx_nx   = widx + ADDR_WIDTH'(1);
          wpos_nx   = '0;
          wstart_nx = vaddr + ADDR_WIDTH'(1);
          vaddr_nx  = vaddr + ADDR_WIDTH'(1);
          state_nx  = ST_RD;
        end else begin
          vaddr_nx = vaddr + ADDR_WIDTH'(1);
          state_nx = ST_SKIP_RD;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      vaddr   <= '0;
      wpos    <= '0;
      widx    <= '0;
      wstart  <= '0;
      qword   <= '0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      maddr_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      vaddr   <= vaddr_nx;
      wpos    <= wpos_nx;
      widx    <= widx_nx;
      wstart  <= wstart_nx;
      match_q <= match_nx;
      ovf_q   <= ovf_nx;
      idx_q   <= idx_nx;
      maddr_q <= maddr_nx;
      busy_q  <= (state_nx != ST_IDLE);
      done_q  <= (state_nx == ST_DONE);
      if (state == ST_IDLE && bus.start) qword <= bus.word;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.match        = match_q;
  assign bus.match_idx    = idx_q;
  assign bus.match_addr   = maddr_q;
  assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_vocab_matcher.sv
module tb_vocab_matcher;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  vocab_matcher_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WORD_LENGTH(3)) vif ();

  vocab_matcher #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WORD_LENGTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] w3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {c, b, a};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    vif.ld_we = 1'b1; vif.ld_addr = a; vif.ld_data = d;
    @(negedge clk);
    vif.ld_we = 1'b0;
  endtask

  task automatic load_catdog();
    logic [7:0] v [9];
    v = '{8'h63, 8'h61, 8'h74, 8'h00, 8'h64, 8'h6F, 8'h67, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) wr(4'(i), v[i]);
  endtask

  // Starts a search and waits for done. ldw: load port write in the start
  // cycle. poke: start + ld_we(addr 1, 0x41) driven while busy.
  task automatic search(input string tag, input logic [23:0] w, input int exp_cyc,
                        input logic em, input logic chk_loc, input logic [3:0] ei,
                        input logic [3:0] ea, input logic eo,
                        input logic ldw, input logic [3:0] la, input logic [7:0] ld,
                        input logic poke);
    int n;
    @(negedge clk);
    vif.word = w; vif.start = 1'b1;
    if (ldw) begin vif.ld_we = 1'b1; vif.ld_addr = la; vif.ld_data = ld; end
    @(posedge clk);
    #1;
    vif.start = 1'b0; vif.ld_we = 1'b0;
    vif.word = ~w;                           // must be ignored after latch
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_busy1"}, 32'(vif.busy), 32'd1);
      if (poke && n == 2) begin
        vif.start = 1'b1; vif.ld_we = 1'b1; vif.ld_addr = 4'd1; vif.ld_data = 8'h41;
      end
      if (poke && n == 3) begin
        vif.start = 1'b0; vif.ld_we = 1'b0;
      end
      if (vif.done) break;
    end
    vif.start = 1'b0; vif.ld_we = 1'b0;
    chk({tag, "_cyc"}, 32'(n), 32'(exp_cyc));
    chk({tag, "_match"}, 32'(vif.match), 32'(em));
    chk({tag, "_ovf"}, 32'(vif.overflow_err), 32'(eo));
    if (chk_loc) begin
      chk({tag, "_idx"}, 32'(vif.match_idx), 32'(ei));
      chk({tag, "_addr"}, 32'(vif.match_addr), 32'(ea));
    end
    @(negedge clk);
    chk({tag, "_done1"}, 32'(vif.done), 32'd0);
    chk({tag, "_idle"}, 32'(vif.busy), 32'd0);
    chk({tag, "_hold"}, 32'(vif.match), 32'(em));
  endtask

  initial begin
    vif.ld_we = 1'b0; vif.ld_addr = '0; vif.ld_data = '0;
    vif.start = 1'b0; vif.word = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy",  32'(vif.busy), 0);
    chk("rst_done",  32'(vif.done), 0);
    chk("rst_match", 32'(vif.match), 0);
    chk("rst_idx",   32'(vif.match_idx), 0);
    chk("rst_addr",  32'(vif.match_addr), 0);
    chk("rst_ovf",   32'(vif.overflow_err), 0);

    load_catdog();
    search("dog", w3(8'h64, 8'h6F, 8'h67), 17, 1, 1, 4'd1, 4'd4, 0, 0, 0, 0, 0);
    search("cow", w3(8'h63, 8'h6F, 8'h77), 19, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    search("ca",  w3(8'h63, 8'h61, 8'h00), 19, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    search("cat", w3(8'h63, 8'h61, 8'h74),  9, 1, 1, 4'd0, 4'd0, 0, 0, 0, 0, 0);
    search("empty", w3(8'h00, 8'h61, 8'h74), 19, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) wr(4'(i), 8'h41);
    search("ovf", w3(8'h41, 8'h41, 8'h41), 33, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // reset in the middle of a search
    load_catdog();
    search("dog2", w3(8'h64, 8'h6F, 8'h67), 17, 1, 1, 4'd1, 4'd4, 0, 0, 0, 0, 0);
    @(negedge clk);
    vif.word = w3(8'h63, 8'h6F, 8'h77); vif.start = 1'b1;
    @(negedge clk);
    vif.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy",  32'(vif.busy), 0);
    chk("mrst_done",  32'(vif.done), 0);
    chk("mrst_match", 32'(vif.match), 0);
    chk("mrst_idx",   32'(vif.match_idx), 0);
    chk("mrst_addr",  32'(vif.match_addr), 0);
    chk("mrst_ovf",   32'(vif.overflow_err), 0);
    rst_n = 1'b1;
    begin
      int dn = 0;
      repeat (25) begin @(negedge clk); if (vif.done) dn++; end
      chk("mrst_nodone", 32'(dn), 0);
    end
    search("dog3", w3(8'h64, 8'h6F, 8'h67), 17, 1, 1, 4'd1, 4'd4, 0, 0, 0, 0, 0);

    // start and ld_we together: search must see the freshly written 'd'
    wr(4'd0, 8'h65); wr(4'd1, 8'h00); wr(4'd2, 8'h00);
    search("stld", w3(8'h64, 8'h00, 8'h00), 5, 1, 1, 4'd0, 4'd0, 0, 1, 4'd0, 8'h64, 0);
    // start/ld_we while busy have no effect
    search("poke", w3(8'h64, 8'h00, 8'h00), 5, 1, 1, 4'd0, 4'd0, 0, 0, 0, 0, 1);
    search("post", w3(8'h64, 8'h00, 8'h00), 5, 1, 1, 4'd0, 4'd0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
